// File: rtl/ps2_ascii_decoder_if.sv
// ps2_ascii_decoder_if
//   Groups the keyboard-side lines and the display-side outputs of the
//   PS/2 ASCII decoder.
//   master : keyboard/driver side (drives ps2_clk/ps2_data, observes outputs)
//   slave  : decoder side (receives ps2_clk/ps2_data, drives outputs)
//   Signals:
//     ps2_clk, ps2_data  raw keyboard lines, asynchronous to clk
//     ascii[7:0]         ASCII of the last printable key, held between presses
//     if_press           one-cycle pulse, ascii valid in the same cycle
//     if_back            one-cycle pulse on Backspace make
//     if_enter           one-cycle pulse on Enter make
//     frame_err          one-cycle pulse when a frame is rejected
interface ps2_ascii_decoder_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] ascii;
  logic       if_press;
  logic       if_back;
  logic       if_enter;
  logic       frame_err;

  modport master (
    output ps2_clk, ps2_data,
    input  ascii, if_press, if_back, if_enter, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output ascii, if_press, if_back, if_enter, frame_err
  );
endinterface

// File: rtl/ps2_ascii_decoder.sv
// ps2_ascii_decoder
//   Receives PS/2 set-2 scan-code frames, tracks Shift/CapsLock and turns
//   make codes into ASCII plus Backspace/Enter pulses for the display stage.
//   Parameters:
//     TIMEOUT_CYCLES  idle clk cycles after which a partial frame is dropped
//   Ports:
//     clk    50 MHz system clock
//     reset  asynchronous, active-high
//     bus    ps2_ascii_decoder_if.slave (keyboard lines in, key events out)
module ps2_ascii_decoder #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               reset,
  ps2_ascii_decoder_if.slave bus
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {RX_IDLE, RX_BITS} rx_state_t;

  logic [2:0]       ps2_clk_sync;
  logic [2:0]       ps2_data_sync;
  logic             fall;
  logic             data_bit;
  rx_state_t        rx_state, rx_state_next;
  logic [3:0]       bit_cnt, bit_cnt_next;
  logic [10:0]      shreg, shreg_next;
  logic [TMO_W-1:0] tmo_cnt, tmo_cnt_next;
  logic [10:0]      frame;
  logic             frame_done;
  logic             frame_good;
  logic             vld_p1;
  logic [7:0]       byte_p1;
  logic             brk, ext, shift_l, shift_r, caps, caps_held;
  logic [8:0]       key_map;

  // Returns {hit, ascii}; hit=0 for codes with no printable mapping.
  function automatic logic [8:0] map_key(input logic [7:0] code,
                                         input logic       shift,
                                         input logic       caps_on);
    logic [7:0] c;
    logic       hit;
    hit = 1'b1;
    c   = 8'h00;
    case (code)
      8'h1C: c = "a";  8'h32: c = "b";  8'h21: c = "c";  8'h23: c = "d";
      8'h24: c = "e";  8'h2B: c = "f";  8'h34: c = "g";  8'h33: c = "h";
      8'h43: c = "i";  8'h3B: c = "j";  8'h42: c = "k";  8'h4B: c = "l";
      8'h3A: c = "m";  8'h31: c = "n";  8'h44: c = "o";  8'h4D: c = "p";
      8'h15: c = "q";  8'h2D: c = "r";  8'h1B: c = "s";  8'h2C: c = "t";
      8'h3C: c = "u";  8'h2A: c = "v";  8'h1D: c = "w";  8'h22: c = "x";
      8'h35: c = "y";  8'h1A: c = "z";
      8'h45: c = shift ? ")" : "0";
      8'h16: c = shift ? "!" : "1";
      8'h1E: c = shift ? "@" : "2";
      8'h26: c = shift ? "#" : "3";
      8'h25: c = shift ? "$" : "4";
      8'h2E: c = shift ? "%" : "5";
      8'h36: c = shift ? "^" : "6";
      8'h3D: c = shift ? "&" : "7";
      8'h3E: c = shift ? "*" : "8";
      8'h46: c = shift ? "(" : "9";
      8'h29: c = 8'h20;
      default: hit = 1'b0;
    endcase
    // Caps only affects letters, and cancels against Shift.
    if (c >= "a" && c <= "z" && (shift ^ caps_on)) c = c - 8'h20;
    return {hit, c};
  endfunction

  // Stage p0: synchronize the raw lines and detect ps2_clk falling edges
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ps2_clk_sync  <= 3'b111;
      ps2_data_sync <= 3'b111;
    end else begin
      ps2_clk_sync  <= {ps2_clk_sync[1:0], bus.ps2_clk};
      ps2_data_sync <= {ps2_data_sync[1:0], bus.ps2_data};
    end
  end

  assign fall     = ps2_clk_sync[2] & ~ps2_clk_sync[1];
  assign data_bit = ps2_data_sync[2];

  // Frame bits shift in LSB first: [0]=start, [8:1]=data, [9]=parity, [10]=stop.
  assign frame      = {data_bit, shreg[10:1]};
  assign frame_done = fall && (rx_state == RX_BITS) && (bit_cnt == 4'd10);
  assign frame_good = ~frame[0] & frame[10] & (^frame[9:1]);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= RX_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      tmo_cnt  <= '0;
    end else begin
      rx_state <= rx_state_next;
      bit_cnt  <= bit_cnt_next;
      shreg    <= shreg_next;
      tmo_cnt  <= tmo_cnt_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state;
    bit_cnt_next  = bit_cnt;
    shreg_next    = shreg;
    tmo_cnt_next  = '0;
    case (rx_state)
      RX_IDLE: begin
        if (fall) begin
          shreg_next    = frame;
          bit_cnt_next  = 4'd1;
          rx_state_next = RX_BITS;
        end
      end
      RX_BITS: begin
        if (fall) begin
          shreg_next = frame;
          if (bit_cnt == 4'd10) begin
            bit_cnt_next  = '0;
            rx_state_next = RX_IDLE;
          end else begin
            bit_cnt_next = bit_cnt + 4'd1;
          end
        end else if (tmo_cnt == TMO_LAST) begin
          // Keyboard went quiet mid-frame: drop it without flagging an error.
          bit_cnt_next  = '0;
          rx_state_next = RX_IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt + TMO_W'(1);
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // Stage p1: frame check and byte register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1        <= 1'b0;
      bus.frame_err <= 1'b0;
    end else begin
      vld_p1        <= frame_done & frame_good;
      bus.frame_err <= frame_done & ~frame_good;
    end
  end

  always_ff @(posedge clk) begin
    if (frame_done) byte_p1 <= frame[8:1];
  end

  assign key_map = map_key(byte_p1, shift_l | shift_r, caps);

  // Stage p2: decode modifiers/prefixes and register the outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.ascii    <= 8'h00;
      bus.if_press <= 1'b0;
      bus.if_back  <= 1'b0;
      bus.if_enter <= 1'b0;
      brk          <= 1'b0;
      ext          <= 1'b0;
      shift_l      <= 1'b0;
      shift_r      <= 1'b0;
      caps         <= 1'b0;
      caps_held    <= 1'b0;
    end else begin
      bus.if_press <= 1'b0;
      bus.if_back  <= 1'b0;
      bus.if_enter <= 1'b0;
      if (vld_p1) begin
        if (byte_p1 == 8'hF0) begin
          brk <= 1'b1;
        end else if (byte_p1 == 8'hE0) begin
          ext <= 1'b1;
        end else begin
          brk <= 1'b0;
          ext <= 1'b0;
          if (brk) begin
            case (byte_p1)
              8'h12:   shift_l   <= 1'b0;
              8'h59:   shift_r   <= 1'b0;
              8'h58:   caps_held <= 1'b0;
              default: ;
            endcase
          end else if (byte_p1 == 8'h5A) begin
            bus.if_enter <= 1'b1;
          end else if (!ext) begin
            case (byte_p1)
              8'h12: shift_l <= 1'b1;
              8'h59: shift_r <= 1'b1;
              8'h58: begin
                // Typematic repeats of CapsLock arrive with caps_held set.
                if (!caps_held) caps <= ~caps;
                caps_held <= 1'b1;
              end
              8'h66: bus.if_back <= 1'b1;
              default: begin
                if (key_map[8]) begin
                  bus.ascii    <= key_map[7:0];
                  bus.if_press <= 1'b1;
                end
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
`timescale 1ns/1ps
module tb_ps2_ascii_decoder;

  localparam int HALF = 10;  // clk cycles per PS/2 half bit

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #10 clk = ~clk;

  ps2_ascii_decoder_if bus();

  ps2_ascii_decoder #(.TIMEOUT_CYCLES(50000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int pulse_cyc = -100;
  int press_cnt = 0, back_cnt = 0, enter_cnt = 0, err_cnt = 0, multi_hi = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.if_press)  begin press_cnt++; pulse_cyc = cyc; end
    if (bus.if_back)   begin back_cnt++;  pulse_cyc = cyc; end
    if (bus.if_enter)  begin enter_cnt++; pulse_cyc = cyc; end
    if (bus.frame_err) err_cnt++;
    if (int'(bus.if_press) + int'(bus.if_back) + int'(bus.if_enter) + int'(bus.frame_err) > 1)
      multi_hi++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic bad_par,
                                           input logic bad_stop);
    return {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
  endfunction

  task automatic ps2_bit(input logic b);
    bus.ps2_data = b;
    wait_cyc(HALF);
    bus.ps2_clk = 1'b0;
    fall_cyc = cyc;
    wait_cyc(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_raw(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    bus.ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  task automatic key(input logic [7:0] b);
    send_raw(mk_frame(b, 1'b0, 1'b0), 11);
  endtask

  // Printable make: exactly one if_press, 4 clk after the raw stop edge
  // (2 synchronizer cycles + 2 pipeline cycles).
  task automatic key_press(input string tag, input logic [7:0] b, input logic [7:0] exp_a);
    int p;
    p = press_cnt;
    key(b);
    chk({tag, "_cnt"}, press_cnt - p, 1);
    chk({tag, "_lat"}, pulse_cyc - fall_cyc, 4);
    chk({tag, "_ascii"}, bus.ascii, exp_a);
  endtask

  // Byte that must produce no pulse and leave ascii alone.
  task automatic key_silent(input string tag, input logic [7:0] b);
    int p;
    logic [7:0] a;
    p = press_cnt + back_cnt + enter_cnt + err_cnt;
    a = bus.ascii;
    key(b);
    chk({tag, "_nopulse"}, press_cnt + back_cnt + enter_cnt + err_cnt - p, 0);
    chk({tag, "_ascii"}, bus.ascii, a);
  endtask

  initial begin
    int p, e;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    reset = 1'b1;
    wait_cyc(5);
    chk("rst_ascii", bus.ascii, 8'h00);
    chk("rst_press", bus.if_press, 1'b0);
    chk("rst_back", bus.if_back, 1'b0);
    chk("rst_enter", bus.if_enter, 1'b0);
    chk("rst_err", bus.frame_err, 1'b0);
    reset = 1'b0;
    wait_cyc(5);

    // Plain make, then break
    key_press("a1", 8'h1C, 8'h61);
    key_silent("brk_f0", 8'hF0);
    key_silent("brk_1c", 8'h1C);

    // Shift held
    key_silent("shl_mk", 8'h12);
    key_press("shA", 8'h1C, 8'h41);
    key_silent("b1", 8'hF0);
    key_silent("b1c", 8'h1C);
    key_silent("b2", 8'hF0);
    key_silent("b12", 8'h12);
    key_press("a2", 8'h1C, 8'h61);

    // CapsLock with auto-repeat, then caps XOR shift
    key_silent("caps1", 8'h58);
    key_silent("caps_rep", 8'h58);
    key_silent("caps_bf0", 8'hF0);
    key_silent("caps_b58", 8'h58);
    key_press("capsA", 8'h1C, 8'h41);
    key_silent("cs_sh", 8'h12);
    key_press("caps_sh_a", 8'h1C, 8'h61);
    key_silent("cs_bf0", 8'hF0);
    key_silent("cs_b12", 8'h12);
    key_press("caps_A2", 8'h1C, 8'h41);
    key_silent("caps_off", 8'h58);
    key_silent("co_bf0", 8'hF0);
    key_silent("co_b58", 8'h58);
    key_press("nocaps_a", 8'h1C, 8'h61);

    // Shifted digit via right shift, then space
    key_silent("shr_mk", 8'h59);
    key_press("bang", 8'h16, 8'h21);
    key_silent("shr_bf0", 8'hF0);
    key_silent("shr_b59", 8'h59);
    key_press("one", 8'h16, 8'h31);
    key_press("space", 8'h29, 8'h20);

    // Backspace, Enter (plain and extended), ignored extended key
    p = back_cnt;
    key(8'h66);
    chk("back_cnt", back_cnt - p, 1);
    chk("back_lat", pulse_cyc - fall_cyc, 4);
    chk("back_ascii", bus.ascii, 8'h20);
    key_silent("ent_e0", 8'hE0);
    p = enter_cnt;
    key(8'h5A);
    chk("xenter_cnt", enter_cnt - p, 1);
    chk("xenter_lat", pulse_cyc - fall_cyc, 4);
    p = enter_cnt;
    key(8'h5A);
    chk("enter_cnt", enter_cnt - p, 1);
    key_silent("x75_e0", 8'hE0);
    key_silent("x75", 8'h75);
    chk("nav_ascii", bus.ascii, 8'h20);

    // Rejected frames: bad parity, bad stop bit
    p = press_cnt; e = err_cnt;
    send_raw(mk_frame(8'h1C, 1'b1, 1'b0), 11);
    chk("par_err", err_cnt - e, 1);
    chk("par_nopress", press_cnt - p, 0);
    chk("par_ascii", bus.ascii, 8'h20);
    e = err_cnt;
    send_raw(mk_frame(8'h1C, 1'b0, 1'b1), 11);
    chk("stop_err", err_cnt - e, 1);
    chk("stop_ascii", bus.ascii, 8'h20);

    // Partial frame abandoned by timeout
    e = err_cnt;
    send_raw(mk_frame(8'h1C, 1'b0, 1'b0), 5);
    wait_cyc(50010);
    key_press("tmo", 8'h1C, 8'h61);
    chk("tmo_noerr", err_cnt - e, 0);

    // Reset mid-frame with Shift held
    key_press("pre_rst", 8'h2C, 8'h74);
    key_silent("pre_rst_sh", 8'h12);
    send_raw(mk_frame(8'h1C, 1'b0, 1'b0), 6);
    #3 reset = 1'b1;
    #1;
    chk("mrst_ascii", bus.ascii, 8'h00);
    chk("mrst_press", bus.if_press, 1'b0);
    chk("mrst_err", bus.frame_err, 1'b0);
    wait_cyc(3);
    reset = 1'b0;
    wait_cyc(3);
    key_press("post_rst", 8'h1C, 8'h61);

    chk("onehot", multi_hi, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
